key_schedule_rev: RTL and testbench
===================================

KEY_SCHEDULE_REV -- requirements
Module: key_schedule_rev

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  load key_in and begin the reverse walk
- key_in  in  128  round-10 key, or the cipher key with KSR_PRECOMPUTE_EN
- out_ready  in  1  consumer accepts round_key this cycle
- round_key  out  128  current round key, word 0 in bits [127:96]
- round_idx  out  4  round number of round_key, 10 down to 0
- out_valid  out  1  round_key/round_idx are valid
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse after round 0 is accepted

Function
REQ-003 The block SHALL emit AES-128 round keys in reverse order, 10 down to 0, for on-the-fly decryption.
REQ-004 The state machine SHALL have states IDLE, (PRE), EMIT.
REQ-005 IDLE with start=1 SHALL register key_in, go to EMIT, and assert out_valid with round_idx=10 the next cycle.
REQ-006 In EMIT, a transfer SHALL occur when out_valid and out_ready are both 1.
REQ-007 On a transfer with round_idx>0, round_key SHALL update next cycle to the previous round key, and round_idx SHALL decrement.
REQ-008 out_valid SHALL stay high between transfers, giving throughput of one key per cycle.
REQ-009 On a transfer with round_idx=0: out_valid drops next cycle, done pulses for one cycle, and the state returns to IDLE.
REQ-010 With out_ready=0, round_key, round_idx and out_valid SHALL hold stable (no skipping, no dropped keys).
REQ-011 Inverse step, for words {a,b,c,d} of round r:
- d'=d^c, c'=c^b, b'=b^a
- a'=a^SubWord(RotWord(d'))^{rc,24'h0}
- rc = round constant of round r
REQ-012 rc SHALL be generated internally, not looked up:
- load value 8'h36 at round 10
- each step: rc_next = (rc>>1) ^ (rc[0] ? 8'h8d : 8'h00)
- sequence: 36,1b,80,40,20,10,08,04,02,01
REQ-013 start SHALL be ignored while busy=1.
REQ-014 Simultaneous start and the final transfer SHALL complete the walk, and the block SHALL start a new walk only on a later start sampled in IDLE.
REQ-015 busy SHALL be 1 from the cycle after an accepted start until the cycle done pulses, inclusive of PRE.

Reset
REQ-016 rst SHALL override start and out_ready, including mid-walk.
REQ-017 rst SHALL set state=IDLE, round_key=0, round_idx=0, out_valid=0, busy=0, done=0, and rc=8'h36.
REQ-018 The first start SHALL be honoured in the first cycle with rst=0.

Configuration
REQ-019 The macro KSR_PRECOMPUTE_EN SHALL select the key_in format.
REQ-020 With KSR_PRECOMPUTE_EN defined:
- key_in is the cipher key
- start enters PRE, which runs 10 forward expansion steps, one per cycle, with forward rc 01,02,...,36
- out_valid stays 0 during PRE
- EMIT begins with round_idx=10 eleven cycles after start
REQ-021 Without KSR_PRECOMPUTE_EN, key_in SHALL be the round-10 key, and the PRE state and forward datapath SHALL not exist.

Structure
REQ-022 Package aes_ksr_pkg SHALL hold:
- the state enum
- constants RC_LAST=8'h36, RC_FIRST=8'h01, RC_INV_POLY=8'h8d, RC_FWD_POLY=8'h1b
- NUM_ROUNDS=10
REQ-023 Sub-module aes_subword SHALL be a combinational SubWord on 32 bits (four S-boxes), instantiated once and shared by PRE and EMIT.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- Start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready=1 -> idx10 = key_in, idx9 = ac7766f319fadc2128d12941575c006e, idx0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses the cycle after idx0 transfer; 11 transfers in 11 consecutive cycles.
- Same stimulus with out_ready toggled pseudo-randomly -> identical key sequence, with outputs stable while out_ready=0.
- start pulsed at round_idx=5 -> ignored; sequence continues unchanged.
- rst asserted at round_idx=4 -> next cycle all outputs 0, state IDLE; subsequent start restarts at idx10.
- KSR_PRECOMPUTE_EN with key_in=2b7e151628aed2a6abf7158809cf4f3c -> out_valid first high 11 cycles after start, with round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Back-to-back walks, start in the cycle after done -> second walk correct; rc restarts at 8'h36.

Source files
------------

// File: rtl/aes_ksr_pkg.sv
// Shared types and constants for the reverse AES-128 key schedule.
// Optional feature macro: KSR_PRECOMPUTE_EN adds the forward PRE state.
package aes_ksr_pkg;

    localparam int         NUM_ROUNDS  = 10;
    localparam logic [7:0] RC_LAST     = 8'h36;
    localparam logic [7:0] RC_FIRST    = 8'h01;
    localparam logic [7:0] RC_INV_POLY = 8'h8d;
    localparam logic [7:0] RC_FWD_POLY = 8'h1b;

`ifdef KSR_PRECOMPUTE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_EMIT} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_EMIT} state_t;
`endif

    // Division by x in GF(2^8): walks the round constants backwards.
    function automatic logic [7:0] rc_inv_next(input logic [7:0] rc);
        return (rc >> 1) ^ (rc[0] ? RC_INV_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] rc_fwd_next(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? RC_FWD_POLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four forward S-box lookups on a 32-bit word.
module aes_subword (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [0:255][7:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/key_schedule_rev.sv
// Emits AES-128 round keys 10 down to 0 with a valid/ready handshake.
// Optional feature macro: KSR_PRECOMPUTE_EN (key_in is the cipher key, PRE expands it first).
module key_schedule_rev
    import aes_ksr_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         out_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         out_valid,
    output logic         busy,
    output logic         done
);

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic [7:0]   r_rc;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_a, w_b, w_c, w_d;
    logic [31:0]  w_d_inv, w_c_inv, w_b_inv;
    logic [31:0]  w_sub_in, w_sub_out, w_a_next;
    logic [127:0] w_key_inv;
    logic         w_xfer;

    assign {w_a, w_b, w_c, w_d} = r_key;

    assign w_d_inv = w_d ^ w_c;
    assign w_c_inv = w_c ^ w_b;
    assign w_b_inv = w_b ^ w_a;

    // Word 0 update has the same form in both directions; only the SubWord source differs.
`ifdef KSR_PRECOMPUTE_EN
    logic [31:0]  w_b_fwd, w_c_fwd, w_d_fwd;
    logic [127:0] w_key_fwd;

    assign w_sub_in  = (r_state == ST_PRE) ? rot_word(w_d) : rot_word(w_d_inv);
    assign w_b_fwd   = w_b ^ w_a_next;
    assign w_c_fwd   = w_c ^ w_b_fwd;
    assign w_d_fwd   = w_d ^ w_c_fwd;
    assign w_key_fwd = {w_a_next, w_b_fwd, w_c_fwd, w_d_fwd};
`else
    assign w_sub_in  = rot_word(w_d_inv);
`endif

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    assign w_a_next  = w_a ^ w_sub_out ^ {r_rc, 24'h0};
    assign w_key_inv = {w_a_next, w_b_inv, w_c_inv, w_d_inv};
    assign w_xfer    = r_valid & out_ready;

    // NOTE: every state bit is assigned with <= so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_rc    <= RC_LAST;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key  <= key_in;
                        r_busy <= 1'b1;
`ifdef KSR_PRECOMPUTE_EN
                        r_state <= ST_PRE;
                        r_idx   <= '0;
                        r_rc    <= RC_FIRST;
`else
                        r_state <= ST_EMIT;
                        r_idx   <= 4'(NUM_ROUNDS);
                        r_rc    <= RC_LAST;
                        r_valid <= 1'b1;
`endif
                    end
                end
`ifdef KSR_PRECOMPUTE_EN
                ST_PRE: begin
                    r_key <= w_key_fwd;
                    if (r_idx == 4'(NUM_ROUNDS - 1)) begin
                        r_state <= ST_EMIT;
                        r_idx   <= 4'(NUM_ROUNDS);
                        r_rc    <= RC_LAST;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                        r_rc  <= rc_fwd_next(r_rc);
                    end
                end
`endif
                ST_EMIT: begin
                    if (w_xfer) begin
                        if (r_idx == 4'd0) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_key <= w_key_inv;
                            r_idx <= r_idx - 4'd1;
                            r_rc  <= rc_inv_next(r_rc);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign round_key = r_key;
    assign round_idx = r_idx;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_key_schedule_rev.sv
// Scoreboard bench for key_schedule_rev using the FIPS-197 example key schedule.
// Works with or without KSR_PRECOMPUTE_EN defined.
module tb_key_schedule_rev;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         out_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         out_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    key_schedule_rev dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .out_ready (out_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

`ifdef KSR_PRECOMPUTE_EN
    localparam int EXP_LAT = 11;
`else
    localparam int EXP_LAT = 1;
`endif

    int           n_tests  = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    int           gcyc     = 0;
    int           first_x  = -1;
    int           last_x   = -1;
    bit           exp_done = 1'b0;
    bit           prev_stall = 1'b0;
    logic [131:0] prev_out;
    logic [131:0] sb[$];
    logic [127:0] rk[11];

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted key against the scoreboard and watches done/hold behaviour.
    always @(negedge clk) begin
        logic [131:0] exp;
        gcyc++;
        if (exp_done || done) check("done_pulse", 132'(done), 132'(exp_done));
        if (done) check("valid_drop", 132'(out_valid), 132'd0);
        exp_done = 1'b0;
        if (done) done_cnt++;
        if (prev_stall) begin
            check("hold_key_idx", {round_idx, round_key}, prev_out);
            check("hold_valid", 132'(out_valid), 132'd1);
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_out   = {round_idx, round_key};
        if (out_valid && out_ready && !rst) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_xfer: got idx %0d, want no transfer", round_idx);
            end else begin
                exp = sb.pop_front();
                check("xfer_key", {round_idx, round_key}, exp);
                if (first_x < 0) first_x = gcyc;
                last_x = gcyc;
                if (exp[131:128] == 4'd0) exp_done = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("rst_key_idx", {round_idx, round_key}, 132'd0);
        check("rst_flags", 132'({out_valid, busy, done}), 132'd0);
    endtask

    // mode 0: out_ready held high, mode 1: random out_ready.
    // poke_idx >= 0 pulses start while that index is shown; rst_idx >= 0 resets there.
    task automatic run_walk(input int mode, input int poke_idx, input int rst_idx);
        int cyc = 0;
        int lat = -1;
        int d0;
        bit poked = 1'b0;
        bit did_rst = 1'b0;
        bit ended = 1'b0;
        for (int r = 10; r >= 0; r--) sb.push_back({4'(r), rk[r]});
        first_x = -1;
        last_x  = -1;
        d0      = done_cnt;
        @(posedge clk); #1;
        rst       = 1'b0;
        start     = 1'b1;
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        while (!ended && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
            if (lat < 0 && out_valid) begin
                lat = cyc;
                check("busy_walk", 132'(busy), 132'd1);
            end
            if (done_cnt != d0 || did_rst) begin
                ended = 1'b1;
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                if (mode == 1) out_ready = 1'($urandom_range(0, 1));
                if (!poked && poke_idx >= 0 && out_valid && round_idx == 4'(poke_idx)) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
                if (rst_idx >= 0 && out_valid && round_idx == 4'(rst_idx)) begin
                    rst     = 1'b1;
                    did_rst = 1'b1;
                end
            end
        end
        if (!ended) begin
            n_tests++;
            n_fail++;
            $display("FAIL walk_timeout: got no done after %0d cycles, want done", cyc);
        end
        if (did_rst) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk); #1;
            check("midwalk_rst_key_idx", {round_idx, round_key}, 132'd0);
            check("midwalk_rst_flags", 132'({out_valid, busy, done}), 132'd0);
            sb.delete();
        end else begin
            check("first_valid_latency", 132'(lat), 132'(EXP_LAT));
            check("sb_empty", 132'(sb.size()), 132'd0);
            if (mode == 0) check("consecutive_xfers", 132'(last_x - first_x), 132'd10);
            if (poke_idx == 0) begin
                repeat (3) begin
                    @(negedge clk); #1;
                    check("idle_after_final", 132'({out_valid, busy}), 132'd0);
                end
            end
        end
    endtask

    initial begin
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
`ifdef KSR_PRECOMPUTE_EN
        key_in = rk[0];
`else
        key_in = rk[10];
`endif
        do_reset();
        run_walk(0, -1, -1);   // full rate, start in first cycle out of reset
        run_walk(1, -1, -1);   // random back-pressure
        run_walk(0, 5, -1);    // start while busy is ignored
        run_walk(0, -1, 4);    // reset mid-walk
        run_walk(0, -1, -1);   // restart after reset
        run_walk(0, 0, -1);    // start coinciding with final transfer
        run_walk(0, -1, -1);
        run_walk(0, -1, -1);   // back-to-back, start the cycle after done
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
